uart_tx_fifo_param: RTL and testbench

Parametrised, buffered UART transmitter for the serial-output path. It contains an internal baud divider and accepts bytes through a ready/valid handshake into a small FIFO. Each word is serialised LSB-first with a configurable data width, optional parity and one or two stop bits. It replaces the fixed 8N1, unbuffered transmitter plus separate tick generator as the transmit side of `top_uart`-style wrappers.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_fifo_param_if.sv | 23 ++
 rtl/uart_sync_fifo.sv | 42 ++++
 rtl/uart_tx_fifo_param.sv | 127 ++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: parity-mode constants and transmitter FSM state encodings
package uart_pkg;
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;
endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// uart_tx_fifo_param_if: word handshake, frame config and serial status of the transmitter
interface uart_tx_fifo_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_BITS-1:0]          s_data;
    logic                          s_valid;
    logic                          s_ready;
    logic [1:0]                    parity_mode;
    logic                          stop2;
    logic                          txd;
    logic                          busy;
    logic                          tx_done;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;
    modport master (
        output s_data, s_valid, parity_mode, stop2,
        input  s_ready, txd, busy, tx_done, fifo_level
    );
    modport slave (
        input  s_data, s_valid, parity_mode, stop2,
        output s_ready, txd, busy, tx_done, fifo_level
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with extra-MSB pointers for full/empty and a level count
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = wr_q == rd_q;
    assign level_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    assign rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    // pointer registers; reset flushes the contents
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end
    // storage write, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: buffered UART transmitter with baud divider, parity and 1/2 stop bits
module uart_tx_fifo_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    uart_tx_fifo_param_if.slave bus
);
    localparam int DIV_COUNT = CLK_FREQ / BAUD_RATE;
    localparam int CW        = $clog2(DIV_COUNT);
    localparam int BW        = $clog2(DATA_BITS + 1);
    localparam int LW        = $clog2(FIFO_DEPTH) + 1;
    if (DIV_COUNT < 2) begin : g_bad_div
        $error("DIV_COUNT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("DATA_BITS must be in 5..9");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two and at least 2");
    end
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, head;
    logic                 par_en_q, par_en_d, par_bit_q, par_bit_d;
    logic                 stop2_q, stop2_d, stop_n_q, stop_n_d;
    logic                 txd_q, txd_d, done_q, done_d;
    logic                 pop, full, empty, bit_end;
    logic [LW-1:0]        level;
    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.s_valid),
        .pop_i   (pop),
        .wdata_i (bus.s_data),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );
    assign bit_end        = cnt_q == CW'(DIV_COUNT - 1);
    assign bus.s_ready    = !full;
    assign bus.txd        = txd_q;
    assign bus.busy       = state_q != ST_IDLE;
    assign bus.tx_done    = done_q;
    assign bus.fifo_level = level;
    // next state: bit timing, shifting, and popping a word from IDLE or at end of stop
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + CW'(1);
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        stop2_d   = stop2_q;
        stop_n_d  = stop_n_q;
        done_d    = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE:   pop = !empty;
            ST_START:  state_d = bit_end ? ST_DATA : ST_START;
            ST_DATA: begin
                if (bit_end && bit_q == BW'(DATA_BITS - 1)) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                    bit_d   = '0;
                end else if (bit_end) begin
                    bit_d   = bit_q + BW'(1);
                    shift_d = shift_q >> 1;
                end
            end
            ST_PARITY: state_d = bit_end ? ST_STOP : ST_PARITY;
            ST_STOP: begin
                if (bit_end && stop2_q && !stop_n_q) begin
                    stop_n_d = 1'b1;
                end else if (bit_end) begin
                    done_d  = 1'b1;
                    pop     = !empty;
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_IDLE;
        endcase
        if (pop) begin
            state_d   = ST_START;
            shift_d   = head;
            par_en_d  = bus.parity_mode == PAR_ODD || bus.parity_mode == PAR_EVEN;
            par_bit_d = (bus.parity_mode == PAR_ODD) ^ (^head);
            stop2_d   = bus.stop2;
            stop_n_d  = 1'b0;
        end
        txd_d = state_d == ST_START  ? 1'b0 :
                state_d == ST_DATA   ? shift_d[0] :
                state_d == ST_PARITY ? par_bit_d : 1'b1;
    end
    // state registers; reset forces the line idle-high immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            stop_n_q  <= 1'b0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            stop_n_q  <= stop_n_d;
            txd_q     <= txd_d;
            done_q    <= done_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: scoreboard bench comparing serial frames against a bench-side frame model
module tb_uart_tx_fifo_param;
    typedef struct packed {
        logic [15:0] bits;
        logic [4:0]  n;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    frame_t sb[$];
    frame_t sb_b[$];
    frame_t cur;
    bit   active = 0;
    bit   gapless = 0;
    int   cyc = 0;
    int   cycle_no = 0;
    int   last_done = -1;
    int   done_cnt = 0;
    int   accepted = 0;
    int   dropped = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_a ();
    uart_tx_fifo_param_if #(.DATA_BITS(5), .FIFO_DEPTH(4)) bus_b ();

    uart_tx_fifo_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .FIFO_DEPTH(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );
    uart_tx_fifo_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(5), .FIFO_DEPTH(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic frame_t mk(input logic [8:0] w, input int nb, input logic [1:0] pm, input logic s2);
        frame_t f;
        int     k;
        logic   p;
        f = '0;
        k = 1;
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f.bits[k] = w[i];
            p = p ^ w[i];
            k++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
            f.bits[k] = (pm == 2'b01) ? ~p : p;
            k++;
        end
        f.bits[k] = 1'b1;
        k++;
        if (s2) begin
            f.bits[k] = 1'b1;
            k++;
        end
        f.n = 5'(k);
        return f;
    endfunction

    task automatic push_a(input logic [7:0] w, input frame_t f);
        int t;
        t = 0;
        @(negedge clk);
        bus_a.s_data  = w;
        bus_a.s_valid = 1'b1;
        while (!bus_a.s_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("push_timeout", t, 0);
        @(posedge clk);
        sb.push_back(f);
        accepted++;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus_a.busy == 1'b0 && bus_a.fifo_level == 0 && !active) && t < 3000);
        if (t >= 3000) check("idle_timeout", t, 0);
        repeat (3) @(negedge clk);
    endtask

    // frame monitor for the 8-bit instance
    initial begin
        forever begin
            @(negedge clk);
            cycle_no++;
            if (bus_a.tx_done === 1'b1) done_cnt++;
            if (rst) begin
                active = 0;
            end else begin
                if (active && cyc == int'(cur.n) * 10) begin
                    check("done_at_end", bus_a.tx_done, 1);
                    check("busy_at_end", bus_a.busy, bus_a.txd === 1'b0);
                    if (gapless && sb.size() != 0) check("no_gap", bus_a.txd, 0);
                    if (gapless && last_done >= 0) check("done_gap", cycle_no - last_done, 100);
                    last_done = cycle_no;
                    active = 0;
                end
                if (!active && bus_a.txd === 1'b0) begin
                    check("sb_nonempty", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        cur = sb.pop_front();
                        cyc = 0;
                        active = 1;
                    end
                end
                if (active) begin
                    check("txd", bus_a.txd, cur.bits[cyc / 10]);
                    check("busy", bus_a.busy, 1);
                    if (cyc > 0) check("done_low", bus_a.tx_done, 0);
                    cyc++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t fb;
        int     t;
        bus_a.s_data      = 8'($urandom);
        bus_a.s_valid     = 1'($urandom);
        bus_a.parity_mode = 2'($urandom);
        bus_a.stop2       = 1'($urandom);
        bus_b.s_data      = 5'($urandom);
        bus_b.s_valid     = 1'($urandom);
        bus_b.parity_mode = 2'($urandom);
        bus_b.stop2       = 1'($urandom);
        repeat (3) @(negedge clk);
        check("rst_txd", bus_a.txd, 1);
        check("rst_ready", bus_a.s_ready, 1);
        check("rst_busy", bus_a.busy, 0);
        check("rst_level", bus_a.fifo_level, 0);
        check("rst_done", bus_a.tx_done, 0);
        check("rst_txd_b", bus_b.txd, 1);
        bus_a.s_valid     = 1'b0;
        bus_b.s_valid     = 1'b0;
        bus_a.parity_mode = 2'b00;
        bus_a.stop2       = 1'b0;
        bus_b.parity_mode = 2'b00;
        bus_b.stop2       = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0xA5 with first-word latency
        bus_a.s_data  = 8'hA5;
        bus_a.s_valid = 1'b1;
        @(posedge clk);
        sb.push_back('{bits: 16'h034A, n: 5'd10});
        accepted++;
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        check("lat_txd_hi", bus_a.txd, 1);
        check("lat_level1", bus_a.fifo_level, 1);
        @(negedge clk);
        check("lat_txd_lo", bus_a.txd, 0);
        check("lat_level0", bus_a.fifo_level, 0);
        wait_idle();

        // even and odd parity, then two stop bits with a mid-frame config change
        bus_a.parity_mode = 2'b10;
        push_a(8'h07, mk(9'h07, 8, 2'b10, 1'b0));
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        wait_idle();
        bus_a.parity_mode = 2'b01;
        push_a(8'h07, mk(9'h07, 8, 2'b01, 1'b0));
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        wait_idle();
        bus_a.parity_mode = 2'b00;
        bus_a.stop2 = 1'b1;
        push_a(8'hA5, mk(9'hA5, 8, 2'b00, 1'b1));
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus_a.stop2 = 1'b0;
        bus_a.parity_mode = 2'b10;
        wait_idle();
        bus_a.parity_mode = 2'b00;

        // back-to-back 0x01..0x05
        gapless = 1;
        last_done = -1;
        for (int i = 1; i <= 5; i++) push_a(8'(i), mk(9'(i), 8, 2'b00, 1'b0));
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        check("full_ready", bus_a.s_ready, 0);
        check("full_level", bus_a.fifo_level, 4);
        wait_idle();
        gapless = 0;

        // reset during data bit 3 with two words queued
        push_a(8'h11, mk(9'h11, 8, 2'b00, 1'b0));
        push_a(8'h22, mk(9'h22, 8, 2'b00, 1'b0));
        push_a(8'h33, mk(9'h33, 8, 2'b00, 1'b0));
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        t = 0;
        while (!(active && cyc >= 44 && cyc <= 47) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("bit3_timeout", t, 0);
        check("pre_rst_level", bus_a.fifo_level, 2);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_txd", bus_a.txd, 1);
        check("mid_rst_level", bus_a.fifo_level, 0);
        check("mid_rst_busy", bus_a.busy, 0);
        sb.delete();
        dropped = 3;
        repeat (3) begin
            @(negedge clk);
            check("mid_rst_done", bus_a.tx_done, 0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_a(8'h3C, mk(9'h3C, 8, 2'b00, 1'b0));
        @(negedge clk);
        bus_a.s_valid = 1'b0;
        wait_idle();
        check("done_count", done_cnt, accepted - dropped);

        // 5-bit instance, 0x15, no parity
        sb_b.push_back('{bits: 16'h006A, n: 5'd7});
        bus_b.s_data  = 5'h15;
        bus_b.s_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_b.s_valid = 1'b0;
        t = 0;
        while (bus_b.txd !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("b_start_timeout", t, 0);
        fb = sb_b.pop_front();
        for (int c = 0; c < 70; c++) begin
            check("b_txd", bus_b.txd, fb.bits[c / 10]);
            @(negedge clk);
        end
        check("b_done", bus_b.tx_done, 1);
        check("b_busy_end", bus_b.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
